// File: rtl/lu_pkg.sv
// Shared encodings for the bit-serial OR/NOR sequencer and its logic unit.
package lu_pkg;

  localparam logic LU_OP_OR  = 1'b0;
  localparam logic LU_OP_NOR = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage : lu_pkg

// File: rtl/lu_serial_seq.sv
// Bit-serial sequencer: walks a WIDTH-bit OR/NOR through one shared 1-bit
// logic unit, LSB first, one bit per clock, with a start/done handshake.
module lu_serial_seq
  import lu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel,
  input  logic             lu_s
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q;
  state_e             state_d;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               op_r;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   result_next;
  logic               load_c;
  logic               step_c;
  logic               last_c;

  assign last_c = (cnt == CNT_W'(WIDTH - 1));

  // Final word: accumulated bits with the top bit taken straight from the unit.
  always_comb begin
    result_next            = acc;
    result_next[WIDTH-1]   = lu_s;
  end

  // Next-state decode, operand capture/step strobes and logic-unit drive.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    lu_a    = 1'b0;
    lu_b    = 1'b0;
    lu_sel  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        lu_a   = a_r[cnt];
        lu_b   = b_r[cnt];
        lu_sel = op_r;
        step_c = 1'b1;
        if (last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= 1'b0;
      acc     <= '0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == S_RUN);
      done    <= (state_d == S_DONE);
      if (load_c) begin
        a_r  <= a;
        b_r  <= b;
        op_r <= op;
        cnt  <= '0;
        acc  <= '0;
      end else if (step_c) begin
        acc[cnt] <= lu_s;
        cnt      <= cnt + CNT_W'(1);
        if (last_c) begin
          result <= result_next;
        end
      end
    end
  end

endmodule : lu_serial_seq
